// File: rtl/cpu_pkg.sv
// Shared opcode map, instruction field helpers and sequencer state encoding
// for the fetch/decode unit and its control-unit neighbour.
package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_MOV  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_MVI  = 4'hC;
  localparam logic [3:0] OP_RSV  = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hE;
  localparam logic [3:0] OP_JMP  = 4'hF;

  localparam logic [1:0] CU_DONE = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_EXEC,
    ST_DRAIN,
    ST_CLEAR,
    ST_HALT
  } fd_state_t;

  function automatic logic [3:0] ir_opcode(input logic [15:0] ir);
    return ir[15:12];
  endfunction

  function automatic logic [5:0] ir_dest(input logic [15:0] ir);
    return ir[11:6];
  endfunction

  function automatic logic [5:0] ir_src(input logic [15:0] ir);
    return ir[5:0];
  endfunction

endpackage

// File: rtl/fd_watchdog.sv
// Execute-phase watchdog: counts enabled cycles since the last clear and
// flags the cycle in which the budget of TIMEOUT cycles is used up.
module fd_watchdog #(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expire = en && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fetch_decode_unit.sv
// Instruction sequencer in front of the CU: fetches ROM words, presents the
// decoded fields until the CU reports done, then clears the CU and advances.
module fetch_decode_unit
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W     = 8,
  parameter int unsigned TIMEOUT  = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  output logic [PC_W-1:0] rom_addr,
  output logic            rom_read,
  input  logic [15:0]     rom_data,
  output logic [3:0]      opcode,
  output logic [5:0]      dest,
  output logic [5:0]      src,
  input  logic [1:0]      cu_state,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted,
  output logic            timeout_err,
  output logic [15:0]     instr_count
);

  fd_state_t       state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic            halted_q, halted_d;
  logic            timeout_err_q, timeout_err_d;
  logic [15:0]     instr_count_q, instr_count_d;
  logic            wd_clr, wd_en, wd_expire;

  fd_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (wd_clr),
    .en    (wd_en),
    .expire(wd_expire)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    halted_d      = halted_q;
    timeout_err_d = timeout_err_q;
    instr_count_d = instr_count_q;
    wd_clr        = 1'b0;
    wd_en         = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        state_d = ST_LATCH;
      end
      ST_LATCH: begin
        ir_d = rom_data;
        unique case (ir_opcode(rom_data))
          OP_HALT: begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end
          OP_JMP: begin
            pc_d    = rom_data[PC_W-1:0];
            state_d = run ? ST_FETCH : ST_IDLE;
          end
          // Reserved opcode is deliberately folded into NOP.
          OP_NOP, OP_RSV: begin
            pc_d    = pc_q + 1'b1;
            state_d = run ? ST_FETCH : ST_IDLE;
          end
          default: begin
            state_d = ST_EXEC;
            wd_clr  = 1'b1;
          end
        endcase
      end
      ST_EXEC: begin
        wd_en = 1'b1;
        // CU completion takes priority over a coincident watchdog expiry.
        if (cu_state == CU_DONE) begin
          state_d = ST_DRAIN;
        end else if (wd_expire) begin
          timeout_err_d = 1'b1;
          state_d       = ST_CLEAR;
        end
      end
      ST_DRAIN: begin
        state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        pc_d          = pc_q + 1'b1;
        instr_count_d = instr_count_q + 16'd1;
        state_d       = run ? ST_FETCH : ST_IDLE;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= PC_W'(RESET_PC);
      ir_q          <= '0;
      halted_q      <= 1'b0;
      timeout_err_q <= 1'b0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      halted_q      <= halted_d;
      timeout_err_q <= timeout_err_d;
      instr_count_q <= instr_count_d;
    end
  end

  // CU-facing fields are live only while the instruction is being executed.
  always_comb begin
    opcode = '0;
    dest   = '0;
    src    = '0;
    if (state_q == ST_EXEC || state_q == ST_DRAIN) begin
      opcode = ir_opcode(ir_q);
      dest   = ir_dest(ir_q);
      src    = ir_src(ir_q);
    end
  end

  assign rom_read    = (state_q == ST_FETCH);
  assign rom_addr    = pc_q;
  assign pc          = pc_q;
  assign busy        = (state_q != ST_IDLE) && (state_q != ST_HALT);
  assign halted      = halted_q;
  assign timeout_err = timeout_err_q;
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Directed bench for fetch_decode_unit with a behavioural ROM and CU/RAM model.
module tb_fetch_decode_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic [7:0]  rom_addr;
  logic        rom_read;
  logic [15:0] rom_data = '0;
  logic [3:0]  opcode;
  logic [5:0]  dest, src;
  logic [1:0]  cu_q = 2'b00;
  logic [1:0]  cu_nx;
  logic [7:0]  pc;
  logic        busy, halted, timeout_err;
  logic [15:0] instr_count;

  logic        run2 = 1'b0;
  logic [7:0]  rom_addr2;
  logic        rom_read2;
  logic [15:0] rom_data2 = '0;
  logic [3:0]  opcode2;
  logic [5:0]  dest2, src2;
  logic [1:0]  cu2 = 2'b00;
  logic [7:0]  pc2;
  logic        busy2, halted2, timeout_err2;
  logic [15:0] instr_count2;

  logic [15:0] rom [256];
  logic [15:0] ram [64];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fq[$];
  int rq[$];
  logic [7:0] aq[$];
  logic [3:0] prev_op = '0;
  int runlen = 0;

  always #5 clk = ~clk;

  fetch_decode_unit #(.PC_W(8), .TIMEOUT(8), .RESET_PC(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .run(run), .rom_addr(rom_addr), .rom_read(rom_read),
    .rom_data(rom_data), .opcode(opcode), .dest(dest), .src(src), .cu_state(cu_q),
    .pc(pc), .busy(busy), .halted(halted), .timeout_err(timeout_err),
    .instr_count(instr_count)
  );

  fetch_decode_unit #(.PC_W(8), .TIMEOUT(8), .RESET_PC(255)) u_dut_hi (
    .clk(clk), .rst_n(rst_n), .run(run2), .rom_addr(rom_addr2), .rom_read(rom_read2),
    .rom_data(rom_data2), .opcode(opcode2), .dest(dest2), .src(src2), .cu_state(cu2),
    .pc(pc2), .busy(busy2), .halted(halted2), .timeout_err(timeout_err2),
    .instr_count(instr_count2)
  );

  always_ff @(posedge clk) begin
    if (rom_read)  rom_data  <= rom[rom_addr];
    if (rom_read2) rom_data2 <= rom[rom_addr2];
  end

  // CU model: MVI 00->11, MOV 00->01->11, ADD/SUB 00->01->10->11, others never finish.
  always_comb begin
    cu_nx = cu_q;
    case (opcode)
      OP_NOP:         cu_nx = 2'b00;
      OP_MVI:         cu_nx = 2'b11;
      OP_MOV:         cu_nx = (cu_q == 2'b00) ? 2'b01 : 2'b11;
      OP_ADD, OP_SUB: cu_nx = (cu_q == 2'b11) ? 2'b11 : cu_q + 2'b01;
      default:        cu_nx = cu_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cu_q <= 2'b00;
    else        cu_q <= cu_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) ram[i] <= '0;
    end else if (opcode != OP_NOP && cu_q != 2'b11 && cu_nx == 2'b11) begin
      case (opcode)
        OP_MVI: ram[dest] <= {10'b0, src};
        OP_MOV: ram[dest] <= ram[src];
        OP_ADD: ram[dest] <= ram[dest] + ram[src];
        OP_SUB: ram[dest] <= ram[dest] - ram[src];
        default: ;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One cycle, observed at the falling edge, with fetch/execute bookkeeping.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (rom_read) begin
      fq.push_back(cyc);
      aq.push_back(rom_addr);
    end
    if (opcode != OP_NOP) begin
      runlen = (opcode == prev_op) ? runlen + 1 : 1;
    end else if (prev_op != OP_NOP) begin
      rq.push_back(runlen);
    end
    prev_op = opcode;
  endtask

  task automatic do_reset();
    run   = 1'b0;
    run2  = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fq.delete();
    rq.delete();
    aq.delete();
    prev_op = '0;
    runlen  = 0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
  endtask

  task automatic run_to_halt(input int budget);
    for (int i = 0; i < budget && !halted; i++) step();
  endtask

  task automatic load_add_prog();
    clear_rom();
    rom[0] = 16'hC043;  // MVI r1,#3
    rom[1] = 16'hC084;  // MVI r2,#4
    rom[2] = 16'h2042;  // ADD r1,r2
    rom[3] = 16'hE000;  // HALT
  endtask

  initial begin
    int seen;
    clear_rom();
    do_reset();

    check("rst_busy",   busy,        0);
    check("rst_halted", halted,      0);
    check("rst_pc",     pc,          0);
    check("rst_opcode", opcode,      0);
    check("rst_read",   rom_read,    0);
    check("rst_count",  instr_count, 0);
    check("rst_tmo",    timeout_err, 0);
    check("rst_pc_hi",  pc2,         8'hFF);

    // MVI r10,#5 then HALT
    clear_rom();
    rom[0] = 16'hC285;
    rom[1] = 16'hE000;
    run = 1'b1;
    run_to_halt(200);
    check("t1_halted", halted,      1);
    check("t1_pc",     pc,          1);
    check("t1_count",  instr_count, 1);
    check("t1_ram10",  ram[10],     5);
    check("t1_lat",    fq.size() >= 2 ? fq[1] - fq[0] : -1, 6);
    check("t1_cu_vis", rq.size() >= 1 ? rq[0] : -1, 3);
    check("t1_busy",   busy,        0);
    check("t1_op0",    opcode,      0);

    // MVI, MVI, ADD, HALT
    do_reset();
    load_add_prog();
    run = 1'b1;
    run_to_halt(200);
    check("t2_ram1",   ram[1],      7);
    check("t2_count",  instr_count, 3);
    check("t2_pc",     pc,          3);
    check("t2_lat_m1", fq.size() >= 4 ? fq[1] - fq[0] : -1, 6);
    check("t2_lat_m2", fq.size() >= 4 ? fq[2] - fq[1] : -1, 6);
    check("t2_lat_add", fq.size() >= 4 ? fq[3] - fq[2] : -1, 8);
    check("t2_add_vis", rq.size() >= 3 ? rq[2] : -1, 5);

    // JMP 5 then HALT
    do_reset();
    clear_rom();
    rom[0] = 16'hF005;
    rom[5] = 16'hE000;
    run = 1'b1;
    run_to_halt(200);
    check("t3_lat",    fq.size() >= 2 ? fq[1] - fq[0] : -1, 2);
    check("t3_addr",   aq.size() >= 2 ? aq[1] : 8'h00, 5);
    check("t3_pc",     pc,          5);
    check("t3_count",  instr_count, 0);
    check("t3_halted", halted,      1);

    // AND never completes in the CU: watchdog retires it
    do_reset();
    clear_rom();
    rom[0] = 16'h4000;
    rom[1] = 16'hE000;
    run = 1'b1;
    run_to_halt(200);
    check("t4_tmo",    timeout_err, 1);
    check("t4_exec",   rq.size() >= 1 ? rq[0] : -1, 8);
    check("t4_lat",    fq.size() >= 2 ? fq[1] - fq[0] : -1, 11);
    check("t4_pc",     pc,          1);
    check("t4_count",  instr_count, 1);
    check("t4_halted", halted,      1);

    // PC wrap on the RESET_PC=255 instance
    do_reset();
    clear_rom();
    rom[255] = 16'h0000;
    rom[0]   = 16'hE000;
    run2 = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && seen < 2; i++) begin
      @(negedge clk);
      if (rom_read2) begin
        check($sformatf("t5_addr%0d", seen), rom_addr2, seen == 0 ? 8'hFF : 8'h00);
        seen++;
      end
    end
    check("t5_fetches", seen, 2);
    repeat (4) @(negedge clk);
    check("t5_halted", halted2,      1);
    check("t5_pc",     pc2,          0);
    check("t5_count",  instr_count2, 0);

    // Asynchronous reset in the middle of ADD
    do_reset();
    load_add_prog();
    run = 1'b1;
    seen = 0;
    for (int i = 0; i < 100 && seen == 0; i++) begin
      step();
      if (opcode == OP_ADD) seen = 1;
    end
    check("t6a_seen_add", seen, 1);
    step();
    rst_n = 1'b0;
    #1;
    check("t6a_opcode", opcode,      0);
    check("t6a_busy",   busy,        0);
    check("t6a_pc",     pc,          0);
    check("t6a_count",  instr_count, 0);
    check("t6a_read",   rom_read,    0);
    @(negedge clk);
    rst_n = 1'b1;

    // run dropped during ADD: instruction completes, unit parks in IDLE
    do_reset();
    load_add_prog();
    run = 1'b1;
    seen = 0;
    for (int i = 0; i < 100 && seen == 0; i++) begin
      step();
      if (opcode == OP_ADD) seen = 1;
    end
    check("t6b_seen_add", seen, 1);
    run = 1'b0;
    repeat (20) step();
    check("t6b_busy",    busy,        0);
    check("t6b_pc",      pc,          3);
    check("t6b_count",   instr_count, 3);
    check("t6b_ram1",    ram[1],      7);
    check("t6b_halted",  halted,      0);
    check("t6b_fetches", fq.size(),   3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
